sum_nb_seq: RTL and testbench

SUM_NB_SEQ -- requirements
Module: sum_nb_seq

---
 rtl/sum_pkg.sv | 15 +
 rtl/sum_chunk.sv | 32 +++
 rtl/sum_nb_seq.sv | 145 ++++++++++++++
 tb/tb_sum_nb_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the chunk-serial adder/subtractor.
package sum_pkg;

   // Default operand width and slice width.
   localparam int W_DEFAULT     = 16;
   localparam int CHUNK_DEFAULT = 4;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/sum_chunk.sv
// CHUNK-bit combinational ripple-carry adder slice. Besides the carry out it
// exposes the carry into its MSB so the caller can derive signed overflow.
module sum_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] A,
   input  logic [CHUNK-1:0] B,
   input  logic             Cin,
   output logic [CHUNK-1:0] S,
   output logic             Cout,
   output logic             Cmsb
);

   // Ripple the carry from LSB to MSB, recording the carry entering the MSB.
   always_comb begin
      logic carry;
      // NOTE: a running variable inside always_comb uses blocking '=' so each
      // iteration sees the carry produced by the previous bit.
      carry = Cin;
      S     = '0;
      Cmsb  = 1'b0;
      for (int i = 0; i < CHUNK; i++) begin
         if (i == CHUNK - 1) begin
            Cmsb = carry;
         end
         S[i]  = A[i] ^ B[i] ^ carry;
         carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
      end
      Cout = carry;
   end

endmodule

// File: rtl/sum_nb_seq.sv
// Multi-cycle adder/subtractor: one sum_chunk slice adder is reused over
// W/CHUNK RUN cycles, LSB slice first, with the carry held in a register.
module sum_nb_seq
   import sum_pkg::*;
#(
   parameter int W     = W_DEFAULT,
   parameter int CHUNK = CHUNK_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Ci,
   input  logic         sub,
   output logic [W-1:0] S,
   output logic         Cout,
   output logic         ovf,
   output logic         busy,
   output logic         done
);

   localparam int NCH   = W / CHUNK;
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCH - 1);

   state_e           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] a_sl, b_sl, ch_s;
   logic             ch_cout, ch_cmsb;

   // Select the operand slices addressed by the current chunk index.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < NCH; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_sl = a_q[k*CHUNK +: CHUNK];
            b_sl = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   sum_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .A    (a_sl),
      .B    (b_sl),
      .Cin  (carry_q),
      .S    (ch_s),
      .Cout (ch_cout),
      .Cmsb (ch_cmsb)
   );

   // Next-state and datapath updates for IDLE/RUN/DONE.
   always_comb begin
      // NOTE: every signal gets its hold value first so no path through the
      // case leaves one unassigned, which would infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               // Subtraction is A + ~B + 1; Ci is only meaningful for add.
               a_d     = A;
               b_d     = sub ? ~B : B;
               carry_d = sub ? 1'b1 : Ci;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NCH; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  s_d[k*CHUNK +: CHUNK] = ch_s;
               end
            end
            carry_d = ch_cout;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               cout_d  = ch_cout;
               ovf_d   = ch_cmsb ^ ch_cout;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state always uses non-blocking '<=' so every register
      // samples the pre-edge value of every other register.
      if (rst) begin
         state_q <= IDLE;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Latched operands: always loaded before use, so they need no reset.
   // NOTE: leaving pure data registers out of reset keeps the reset net small
   // and is safe because no output depends on them until a start loads them.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   assign S    = s_q;
   assign Cout = cout_q;
   assign ovf  = ovf_q;
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_sum_nb_seq.sv
// Self-checking bench for sum_nb_seq (W=16, CHUNK=4): an arithmetic reference
// model with cycle-count timing, a per-cycle comparator, and directed vectors
// with hand-computed results.
module tb_sum_nb_seq;

   localparam int W   = 16;
   localparam int CH  = 4;
   localparam int NCH = W / CH;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         v;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A, B;
   logic         Ci, sub;
   logic [W-1:0] S;
   logic         Cout, ovf, busy, done;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   sum_nb_seq #(
      .W     (W),
      .CHUNK (CH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Ci    (Ci),
      .sub   (sub),
      .S     (S),
      .Cout  (Cout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic using plain integer math.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic ci, input logic sb);
      res_t r;
      int   u, sg;
      if (sb) begin
         r.s = a - b;
         r.c = (a >= b);
         sg  = int'($signed(a)) - int'($signed(b));
      end else begin
         u   = int'(a) + int'(b) + int'(ci);
         r.s = u[W-1:0];
         r.c = (u > 65535);
         sg  = int'($signed(a)) + int'($signed(b)) + int'(ci);
      end
      r.v = (sg > 32767) || (sg < -32768);
      return r;
   endfunction

   // Timing model: m_cnt is cycles since acceptance (0 = idle, NCH+1 = done).
   int   m_cnt = 0;
   res_t m_pend, m_res;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt <= 0;
         m_res <= '0;
      end else if (m_cnt == 0) begin
         if (start) begin
            m_pend <= model(A, B, Ci, sub);
            m_cnt  <= 1;
         end
      end else if (m_cnt == NCH) begin
         m_res <= m_pend;
         m_cnt <= NCH + 1;
      end else if (m_cnt == NCH + 1) begin
         m_cnt <= 0;
      end else begin
         m_cnt <= m_cnt + 1;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_cnt != 0);
         check("done", done, m_cnt == NCH + 1);
         if (m_cnt == 0 || m_cnt == NCH + 1) begin
            check("S", S, m_res.s);
            check("Cout", Cout, m_res.c);
            check("ovf", ovf, m_res.v);
         end
      end
   end

   // mode 0: plain; 1: second start + new operands mid-RUN;
   // 2: operands change mid-RUN; 3: start held high during DONE.
   task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb, input logic [W-1:0] es,
                         input logic ec, input logic ev, input int mode);
      bit seen = 1'b0;
      A = a; B = b; Ci = ci; sub = sb; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n <= 20 && !seen; n++) begin
         @(negedge clk);
         if (mode == 1 && n == 2) begin
            start = 1'b1; A = 16'hAAAA; B = 16'h5555; sub = ~sb; Ci = ~ci;
         end
         if (mode == 1 && n == 3) start = 1'b0;
         if (mode == 2 && n == 2) begin
            A = ~a; B = ~b;
         end
         if (done) begin
            seen = 1'b1;
            check({nm, "_latency"}, n, NCH + 1);
            check({nm, "_S"}, S, es);
            check({nm, "_Cout"}, Cout, ec);
            check({nm, "_ovf"}, ovf, ev);
            if (mode == 3) start = 1'b1;
         end
      end
      if (!seen) check({nm, "_done_timeout"}, 0, 1);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_S", S, 0);
      check("reset_Cout", Cout, 0);
      check("reset_ovf", ovf, 0);
      chk_en = 1'b1;
      @(posedge clk); #1;

      run_op("add",      16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 0);
      run_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
      run_op("pos_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
      run_op("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
      run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
      run_op("carry_in", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 0);
      run_op("sub_ci",   16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 3);
      run_op("busy_st",  16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1);
      run_op("busy_ab",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 2);

      // Reset asserted during the third RUN cycle aborts the operation.
      A = 16'h1234; B = 16'h4321; Ci = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_S", S, 0);
      check("abort_Cout", Cout, 0);
      check("abort_ovf", ovf, 0);
      repeat (8) @(negedge clk);
      @(posedge clk); #1;

      run_op("post_rst", 16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
